clock_segment_packer: RTL and testbench
=======================================

// Module: clock_segment_packer
// PURPOSE
//  Upstream feeder for the clock-segment FIFO in the ti_clk domain. Packs eight
//  16-bit pipe-in words (endpoint 0x80) into one 128-bit segment record:
//  on_counts[127:80], off_counts[79:32], repeat_counts[31:0].
//  Checks each record, then writes it to the FIFO write port.
//  Counts accepted, dropped and rejected segments for wire-out polling.
// PARAMETERS
//  MIN_PERIOD  2  minimum on_counts+off_counts for a record with repeat_counts!=0
// PORTS
//  ti_clk       in   1    host-interface clock; all logic on posedge
//  reset_n      in   1    synchronous, active-low reset
//  clear        in   1    sync pulse (trigger-in): discard partial record, zero counters/flags
//  pipe_write   in   1    pipe word strobe; one word per asserted cycle, no back-pressure
//  pipe_data    in   16   pipe word
//  fifo_full    in   1    FIFO full flag, write-clock domain
//  fifo_din     out  128  assembled record, held stable while fifo_wr_en is high
//  fifo_wr_en   out  1    one-cycle FIFO write strobe
//  word_index   out  3    index of next expected word, 0..7
//  seg_count    out  16   records written to the FIFO, saturating
//  drop_count   out  16   valid records lost to fifo_full, saturating
//  status       out  4    [0] overflow sticky, [1] invalid sticky, [2] partial pending, [3] commit busy
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge) sets every output and internal reg to 0 and discards any partial record.
//  - Word order is MSW first: word k fills bits [127-16k -: 16], so word0 -> [127:112] and word7 -> [15:0].
//  - ACCUM: each pipe_write stores pipe_data and increments word_index.
//    - word_index wraps 7->0 on the 8th word; that cycle loads the record register.
//    - The next cycle is COMMIT.
//  - COMMIT lasts one cycle and is fixed 1-cycle latency after the 8th word's posedge.
//    - It overlaps ACCUM: word0 of the next record may arrive in the COMMIT cycle and is captured normally.
//    - Back-to-back records at one word per cycle are sustained.
//    - status[3]=1 during COMMIT.
//  - Validity: a record is invalid iff repeat_counts!=0 and (on_counts+off_counts) < MIN_PERIOD.
//    - Compute the sum at 49 bits with no wrap.
//    - repeat_counts==0 is the retrigger-wait record and is always valid, including on_counts==0.
//  - COMMIT outcomes, checked in priority order:
//    - invalid record: fifo_wr_en=0, status[1]<=1, and no counter changes.
//    - valid and fifo_full=1 in the COMMIT cycle: fifo_wr_en=0, drop_count+1, status[0]<=1.
//    - valid and fifo_full=0: fifo_wr_en=1 for exactly this cycle, fifo_din=record, seg_count+1.
//  - Counters saturate at 16'hFFFF and never wrap.
//  - status[2]=1 whenever word_index!=0.
//  - clear=1 takes priority over pipe_write in the same cycle:
//    - the word is discarded and word_index<=0;
//    - counters and sticky flags go to 0.
//    - A COMMIT already scheduled for this cycle still completes its FIFO write. Its count increment is discarded, so the counters read 0 afterwards.
//  - Reset mid-record or mid-COMMIT: no write is issued and the partial data is lost.
//  - fifo_din holds the last record between writes. It is only meaningful when fifo_wr_en=1.
// TESTING
//  1. Feed 8 words 0000,0000,0005, 0000,0000,0003, 0000,000A.
//     Expect fifo_wr_en one cycle after word7 with fifo_din={48'd5,48'd3,32'd10}; seg_count=1.
//  2. Feed two records on 16 consecutive cycles.
//     Expect two single-cycle writes, exactly 8 cycles apart; seg_count=2; word_index ends at 0.
//  3. Hold fifo_full=1 during COMMIT of a valid record.
//     Expect no write, drop_count=1, status[0]=1; the next record with fifo_full=0 is written.
//  4. Send a record with on=1, off=0, repeat=4.
//     Expect no write and status[1]=1. Then send on=0, off=0, repeat=0: it is written and seg_count increments.
//  5. Send 5 words, then clear together with the 6th word.
//     Expect word_index=0 and status=0. The next 8 words form a clean record, written as sent.
//  6. Send 3 words, then reset_n=0 for one cycle.
//     Expect all outputs 0. Preload seg_count to FFFF and write once more: it stays FFFF.

Source files
------------

// File: rtl/clock_segment_packer.sv
// Clock-segment packer: assembles eight 16-bit pipe words into one 128-bit
// segment record, validates it and writes it to the segment FIFO.
module clock_segment_packer #(
    parameter int MIN_PERIOD = 2
) (
    input  logic         ti_clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         pipe_write,
    input  logic [15:0]  pipe_data,
    input  logic         fifo_full,
    output logic [127:0] fifo_din,
    output logic         fifo_wr_en,
    output logic [2:0]   word_index,
    output logic [15:0]  seg_count,
    output logic [15:0]  drop_count,
    output logic [3:0]   status
);

    logic [2:0]   idx_q, idx_d;
    logic [111:0] buf_q, buf_d;
    logic [127:0] rec_q, rec_d;
    logic         commit_q, commit_d;
    logic [15:0]  seg_q, seg_d;
    logic [15:0]  drop_q, drop_d;
    logic         ovf_q, ovf_d;
    logic         inv_q, inv_d;

    logic [48:0]  period;
    logic         rec_invalid;
    logic         wr_ok;
    logic         drop_ev;
    logic         inv_ev;

    // Record check and commit outcome for the record loaded last cycle
    always_comb begin
        period      = {1'b0, rec_q[127:80]} + {1'b0, rec_q[79:32]};
        rec_invalid = (rec_q[31:0] != 32'd0) && (period < 49'(MIN_PERIOD));
        wr_ok       = commit_q && !rec_invalid && !fifo_full;
        drop_ev     = commit_q && !rec_invalid && fifo_full;
        inv_ev      = commit_q && rec_invalid;
    end

    // Next-state: word capture, record load, counters and sticky flags
    always_comb begin
        idx_d    = idx_q;
        buf_d    = buf_q;
        rec_d    = rec_q;
        commit_d = 1'b0;
        seg_d    = seg_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
        if (clear) begin
            idx_d  = 3'd0;
            seg_d  = 16'd0;
            drop_d = 16'd0;
            ovf_d  = 1'b0;
            inv_d  = 1'b0;
        end else begin
            if (pipe_write) begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    rec_d    = {buf_q, pipe_data};
                    commit_d = 1'b1;
                end else begin
                    for (int k = 0; k < 7; k++) begin
                        if (idx_q == 3'(k)) begin
                            buf_d[111-16*k -: 16] = pipe_data;
                        end
                    end
                end
            end
            if (wr_ok && seg_q != 16'hFFFF) begin
                seg_d = seg_q + 16'd1;
            end
            if (drop_ev && drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
            ovf_d = ovf_q | drop_ev;
            inv_d = inv_q | inv_ev;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge ti_clk) begin
        if (!reset_n) begin
            idx_q    <= 3'd0;
            buf_q    <= '0;
            rec_q    <= '0;
            commit_q <= 1'b0;
            seg_q    <= 16'd0;
            drop_q   <= 16'd0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            rec_q    <= rec_d;
            commit_q <= commit_d;
            seg_q    <= seg_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
        end
    end

    // A write never escapes while reset is being applied
    assign fifo_wr_en = wr_ok & reset_n;
    assign fifo_din   = rec_q;
    assign word_index = idx_q;
    assign seg_count  = seg_q;
    assign drop_count = drop_q;
    assign status     = {commit_q, idx_q != 3'd0, inv_q, ovf_q};

endmodule

// File: tb/tb_clock_segment_packer.sv
// Bench for clock_segment_packer: directed scenarios plus randomized records
// checked every cycle against a record-level reference model.
module tb_clock_segment_packer;

    localparam int MIN = 2;

    logic         ti_clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear = 1'b0;
    logic         pipe_write = 1'b0;
    logic [15:0]  pipe_data = 16'd0;
    logic         fifo_full = 1'b0;
    logic [127:0] fifo_din;
    logic         fifo_wr_en;
    logic [2:0]   word_index;
    logic [15:0]  seg_count;
    logic [15:0]  drop_count;
    logic [3:0]   status;

    clock_segment_packer #(.MIN_PERIOD(MIN)) dut (
        .ti_clk(ti_clk), .reset_n(reset_n), .clear(clear),
        .pipe_write(pipe_write), .pipe_data(pipe_data),
        .fifo_full(fifo_full), .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en), .word_index(word_index),
        .seg_count(seg_count), .drop_count(drop_count),
        .status(status)
    );

    always #5 ti_clk = ~ti_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int wr_times[$];

    logic [15:0]  m_words[$];
    logic [127:0] m_rec;
    bit           m_pend;
    int           m_seg, m_drop;
    bit           m_ovf, m_inv;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid(logic [127:0] r);
        longint unsigned s;
        s = 64'(r[127:80]) + 64'(r[79:32]);
        return (r[31:0] == 32'd0) || (s >= 64'(MIN));
    endfunction

    function automatic logic [127:0] pack(logic [15:0] q[$]);
        logic [127:0] r = '0;
        foreach (q[k]) r[127-16*k -: 16] = q[k];
        return r;
    endfunction

    task automatic model_zero();
        m_words.delete();
        m_rec = '0; m_pend = 0;
        m_seg = 0; m_drop = 0; m_ovf = 0; m_inv = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; pipe_write = 1'b0; clear = 1'b0; fifo_full = 1'b0;
        @(posedge ti_clk); #1;
        reset_n = 1'b1;
        model_zero();
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model
    task automatic cyc(bit wr, logic [15:0] d, bit clr, bit full);
        bit exp_wr;
        logic [3:0] exp_st;
        pipe_write = wr; pipe_data = d; clear = clr; fifo_full = full;
        @(negedge ti_clk);
        exp_wr = m_pend && m_valid(m_rec) && !full;
        exp_st = {m_pend, m_words.size() != 0, m_inv, m_ovf};
        chk("wr_en", 128'(fifo_wr_en), 128'(exp_wr));
        if (exp_wr) chk("din", fifo_din, m_rec);
        if (fifo_wr_en) wr_times.push_back(cyc_n);
        chk("word_index", 128'(word_index), 128'(m_words.size()));
        chk("status", 128'(status), 128'(exp_st));
        chk("seg_count", 128'(seg_count), 128'(m_seg));
        chk("drop_count", 128'(drop_count), 128'(m_drop));
        if (m_pend) begin
            if (!m_valid(m_rec)) m_inv = 1;
            else if (full) begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end else if (m_seg < 65535) m_seg++;
        end
        m_pend = 0;
        if (clr) begin
            m_words.delete();
            m_seg = 0; m_drop = 0; m_ovf = 0; m_inv = 0;
        end else if (wr) begin
            m_words.push_back(d);
            if (m_words.size() == 8) begin
                m_rec = pack(m_words);
                m_pend = 1;
                m_words.delete();
            end
        end
        cyc_n++;
        @(posedge ti_clk); #1;
    endtask

    task automatic send_rec(logic [127:0] r, bit full, bit b2b);
        for (int k = 0; k < 8; k++) cyc(1'b1, r[127-16*k -: 16], 1'b0, 1'b0);
        if (!b2b) cyc(1'b0, 16'd0, 1'b0, full);
    endtask

    initial begin
        logic [127:0] r;
        model_zero();
        do_reset();
        chk("rst_din", fifo_din, 128'd0);
        cyc(0, 0, 0, 0);

        // 1: basic record
        send_rec({48'd5, 48'd3, 32'd10}, 0, 0);
        chk("t1_seg", 128'(seg_count), 128'd1);

        // 2: two back-to-back records
        wr_times.delete();
        send_rec({48'd7, 48'd9, 32'd1}, 0, 1);
        send_rec({48'd100, 48'd2, 32'd0}, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t2_nwr", 128'(wr_times.size()), 128'd2);
        if (wr_times.size() == 2)
            chk("t2_gap", 128'(wr_times[1] - wr_times[0]), 128'd8);
        chk("t2_idx", 128'(word_index), 128'd0);

        // 3: FIFO full at commit, then a normal write
        send_rec({48'd4, 48'd4, 32'd3}, 1, 0);
        chk("t3_drop", 128'(drop_count), 128'd1);
        chk("t3_ovf", 128'(status[0]), 128'd1);
        send_rec({48'd6, 48'd1, 32'd2}, 0, 0);

        // 4: invalid record, then retrigger-wait record
        send_rec({48'd1, 48'd0, 32'd4}, 0, 0);
        chk("t4_inv", 128'(status[1]), 128'd1);
        send_rec(128'd0, 0, 0);

        // 5: clear with the 6th word
        for (int k = 0; k < 5; k++) cyc(1, 16'(k + 1), 0, 0);
        cyc(1, 16'h00EE, 1, 0);
        chk("t5_idx", 128'(word_index), 128'd0);
        chk("t5_status", 128'(status), 128'd0);
        send_rec({48'h1234_5678_9ABC, 48'h0000_0000_0001, 32'hDEAD_BEEF}, 0, 0);

        // boundary: on+off exactly MIN with repeat, and MIN-1
        send_rec({48'd1, 48'd1, 32'd1}, 0, 0);
        send_rec({48'd0, 48'd1, 32'hFFFF_FFFF}, 0, 0);
        // boundary: 49-bit sum without wrap
        send_rec({48'hFFFF_FFFF_FFFF, 48'd1, 32'd5}, 0, 0);

        // random records with gaps, FIFO-full and occasional clear
        for (int n = 0; n < 60; n++) begin
            int mode = int'($urandom_range(0, 3));
            r = {$urandom, $urandom, $urandom, $urandom};
            if (mode == 0) r[31:0] = 32'd0;
            if (mode == 1) begin
                r[127:32] = '0;
                r[80] = 1'($urandom_range(0, 1));
                if (r[31:0] == 0) r[0] = 1'b1;
            end
            for (int k = 0; k < 8; k++) begin
                int gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++)
                    cyc(0, 16'($urandom), 0, 1'($urandom_range(0, 3) == 0));
                cyc(1, r[127-16*k -: 16], 1'($urandom_range(0, 120) == 0),
                    1'($urandom_range(0, 3) == 0));
            end
        end
        for (int g = 0; g < 3; g++) cyc(0, 0, 0, 1'($urandom_range(0, 1)));

        // 6: reset mid-record, then counter saturation
        for (int k = 0; k < 3; k++) cyc(1, 16'h0011, 0, 0);
        do_reset();
        chk("t6_din", fifo_din, 128'd0);
        cyc(0, 0, 0, 0);
        force dut.seg_q = 16'hFFFF;
        #1;
        release dut.seg_q;
        m_seg = 65535;
        send_rec({48'd2, 48'd2, 32'd2}, 0, 0);
        chk("t6_sat", 128'(seg_count), 128'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
